// File: rtl/lidar_gate_scheduler.sv
// Per-pulse range-gate sequencer for the lidar FFT datapath: trigger -> delay -> N gates,
// with pulse accumulation counting and a req/ack handoff of the finished spectrum.
module lidar_gate_scheduler #(
    parameter int unsigned GATE_CLKS = 512,
    parameter int unsigned GATE_W    = 8,
    parameter int unsigned ACC_W     = 16
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              enable_i,
    input  logic              trig_i,
    input  logic [15:0]       trig_delay_i,
    input  logic [GATE_W-1:0] gate_num_i,
    input  logic [ACC_W-1:0]  acc_num_i,
    input  logic              rd_ack_i,
    output logic              data_en_o,
    output logic              frame_start_o,
    output logic              frame_last_o,
    output logic [GATE_W-1:0] gate_index_o,
    output logic              acc_first_o,
    output logic              rd_req_o,
    output logic              busy_o,
    output logic              trig_miss_o,
    output logic [15:0]       miss_cnt_o
);

    localparam int unsigned CNT_W = (GATE_CLKS > 1) ? $clog2(GATE_CLKS) : 1;
    localparam logic [CNT_W-1:0] CLK_LAST = CNT_W'(GATE_CLKS - 1);

    typedef enum logic [2:0] {StIdle, StArmed, StDelay, StGate, StReadout} state_e;

    state_e             state_q, state_d;
    logic               trig_q;
    logic [15:0]        dly_cnt_q, dly_cnt_d;
    logic [CNT_W-1:0]   clk_cnt_q, clk_cnt_d;
    logic [GATE_W-1:0]  gate_idx_q, gate_idx_d;
    logic [ACC_W-1:0]   pulse_cnt_q, pulse_cnt_d;
    logic [15:0]        dly_lat_q, dly_lat_d;
    logic [GATE_W-1:0]  gate_last_q, gate_last_d;
    logic [ACC_W-1:0]   acc_lat_q, acc_lat_d;
    logic [15:0]        miss_cnt_q, miss_cnt_d;

    logic               trig_edge, latch_cfg, missed, gate_on;
    logic [ACC_W-1:0]   pulse_inc;

    assign trig_edge = trig_i & ~trig_q;
    assign pulse_inc = pulse_cnt_q + ACC_W'(1);

    always_comb begin
        state_d     = state_q;
        dly_cnt_d   = dly_cnt_q;
        clk_cnt_d   = clk_cnt_q;
        gate_idx_d  = gate_idx_q;
        pulse_cnt_d = pulse_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        dly_lat_d   = dly_lat_q;
        gate_last_d = gate_last_q;
        acc_lat_d   = acc_lat_q;
        latch_cfg   = 1'b0;
        missed      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (enable_i) begin
                    state_d     = StArmed;
                    latch_cfg   = 1'b1;
                    pulse_cnt_d = '0;
                    miss_cnt_d  = '0;
                end
            end
            StArmed: begin
                if (!enable_i) begin
                    state_d = StIdle;
                end else if (trig_edge) begin
                    clk_cnt_d  = '0;
                    gate_idx_d = '0;
                    dly_cnt_d  = dly_lat_q;
                    state_d    = (dly_lat_q == 16'd0) ? StGate : StDelay;
                end
            end
            StDelay: begin
                missed    = trig_edge;
                dly_cnt_d = dly_cnt_q - 16'd1;
                if (dly_cnt_q == 16'd1) begin
                    state_d = StGate;
                end
            end
            StGate: begin
                missed = trig_edge;
                if (clk_cnt_q == CLK_LAST) begin
                    clk_cnt_d = '0;
                    if (gate_idx_q == gate_last_q) begin
                        // Pulse complete; enable only matters once the pulse is finished.
                        pulse_cnt_d = pulse_inc;
                        if (pulse_inc == acc_lat_q) begin
                            state_d = StReadout;
                        end else if (!enable_i) begin
                            state_d = StIdle;
                        end else begin
                            state_d = StArmed;
                        end
                    end else begin
                        gate_idx_d = gate_idx_q + GATE_W'(1);
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_W'(1);
                end
            end
            StReadout: begin
                missed = trig_edge;
                if (rd_ack_i) begin
                    pulse_cnt_d = '0;
                    latch_cfg   = 1'b1;
                    state_d     = enable_i ? StArmed : StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (latch_cfg) begin
            dly_lat_d   = trig_delay_i;
            gate_last_d = (gate_num_i == '0) ? '0 : gate_num_i - GATE_W'(1);
            acc_lat_d   = (acc_num_i == '0) ? ACC_W'(1) : acc_num_i;
        end

        if (missed && (miss_cnt_q != 16'hFFFF)) begin
            miss_cnt_d = miss_cnt_q + 16'd1;
        end

        gate_on = (state_d == StGate);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q       <= StIdle;
            trig_q        <= 1'b0;
            dly_cnt_q     <= '0;
            clk_cnt_q     <= '0;
            gate_idx_q    <= '0;
            pulse_cnt_q   <= '0;
            dly_lat_q     <= '0;
            gate_last_q   <= '0;
            acc_lat_q     <= '0;
            miss_cnt_q    <= '0;
            data_en_o     <= 1'b0;
            frame_start_o <= 1'b0;
            frame_last_o  <= 1'b0;
            gate_index_o  <= '0;
            acc_first_o   <= 1'b0;
            rd_req_o      <= 1'b0;
            busy_o        <= 1'b0;
            trig_miss_o   <= 1'b0;
        end else begin
            state_q       <= state_d;
            trig_q        <= trig_i;
            dly_cnt_q     <= dly_cnt_d;
            clk_cnt_q     <= clk_cnt_d;
            gate_idx_q    <= gate_idx_d;
            pulse_cnt_q   <= pulse_cnt_d;
            dly_lat_q     <= dly_lat_d;
            gate_last_q   <= gate_last_d;
            acc_lat_q     <= acc_lat_d;
            miss_cnt_q    <= miss_cnt_d;
            // Outputs decode next state so they line up with the state they describe.
            data_en_o     <= gate_on;
            frame_start_o <= gate_on && (clk_cnt_d == '0);
            frame_last_o  <= gate_on && (clk_cnt_d == CLK_LAST);
            gate_index_o  <= gate_on ? gate_idx_d : '0;
            acc_first_o   <= gate_on && (pulse_cnt_d == '0);
            rd_req_o      <= (state_d == StReadout);
            busy_o        <= (state_d != StIdle);
            trig_miss_o   <= missed;
        end
    end

    assign miss_cnt_o = miss_cnt_q;

endmodule
